pair_sort_pipe: RTL and testbench

- Two-stage valid/ready pipeline that accepts an operand pair (a, b), orders it by a registered compare-and-swap, and emits (lo, hi) with a swapped flag.
- Sits directly downstream of the register-swap stage: it consumes the 13-bit a/b pair that stage produces and turns the unconditional exchange into a data-dependent, flow-controlled one.
- Also keeps a saturating count of pairs that actually required a swap.

---
 rtl/pair_sort_pkg.sv | 27 ++
 rtl/pair_sort_pipe_if.sv | 24 ++
 rtl/pipe_slice.sv | 41 ++++
 rtl/pair_sort_pipe.sv | 88 ++++++++
 tb/tb_pair_sort_pipe.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pair_sort_pkg.sv
// Shared types and constants for the pair sorting pipeline.
package pair_sort_pkg;

    localparam int unsigned PAIR_W = 13;

    localparam bit ASCEND  = 1'b0;
    localparam bit DESCEND = 1'b1;

    typedef struct packed {
        logic [PAIR_W-1:0] a;
        logic [PAIR_W-1:0] b;
    } pair_t;

    typedef struct packed {
        logic [PAIR_W-1:0] lo;
        logic [PAIR_W-1:0] hi;
        logic              swapped;
    } result_t;

    // Unsigned compare deciding whether the pair must be exchanged; ties never swap.
    function automatic logic need_swap(input logic [PAIR_W-1:0] a,
                                       input logic [PAIR_W-1:0] b,
                                       input bit                desc);
        return desc ? (a < b) : (a > b);
    endfunction

endpackage

// File: rtl/pair_sort_pipe_if.sv
// Input/output valid-ready bus of the pair sorting pipeline.
interface pair_sort_pipe_if import pair_sort_pkg::*; #(
    parameter int unsigned W = PAIR_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_lo;
    logic [W-1:0] out_hi;
    logic         out_swapped;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_lo, out_hi, out_swapped
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_lo, out_hi, out_swapped
    );
endinterface

// File: rtl/pipe_slice.sv
// One valid/ready register stage; accepts new data whenever empty or draining.
module pipe_slice #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          ready_c,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
);
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;

    always_comb begin
        ready_c = !valid_q || out_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_c) begin
            valid_d = in_valid;
        end
        if (in_valid && ready_c) begin
            data_d = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
endmodule

// File: rtl/pair_sort_pipe.sv
// Two-stage compare-and-swap pipeline emitting ordered (lo, hi) pairs plus a
// saturating count of delivered pairs that needed an exchange.
module pair_sort_pipe import pair_sort_pkg::*; #(
    parameter int unsigned W       = PAIR_W,
    parameter bit          DESCEND = ASCEND,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    pair_sort_pipe_if.slave  bus,
    input  logic             clear_count,
    output logic [CNT_W-1:0] swap_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pair_t   s1_in;
    pair_t   s1_data;
    logic    s1_valid;
    logic    s1_ready_c;
    logic    s2_take;
    result_t res_c;
    result_t s2_data;
    logic    s2_valid;

    always_comb begin
        s1_in   = '0;
        s1_in.a = PAIR_W'(bus.in_a);
        s1_in.b = PAIR_W'(bus.in_b);
    end

    pipe_slice #(.DW($bits(pair_t))) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_data   (s1_in),
        .ready_c   (s1_ready_c),
        .out_valid (s1_valid),
        .out_data  (s1_data),
        .out_ready (s2_take)
    );

    // Compare/swap sits between the stages so the result is registered in S2.
    always_comb begin
        res_c         = '0;
        res_c.swapped = need_swap(s1_data.a, s1_data.b, DESCEND);
        res_c.lo      = res_c.swapped ? s1_data.b : s1_data.a;
        res_c.hi      = res_c.swapped ? s1_data.a : s1_data.b;
    end

    pipe_slice #(.DW($bits(result_t))) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_data   (res_c),
        .ready_c   (s2_take),
        .out_valid (s2_valid),
        .out_data  (s2_data),
        .out_ready (bus.out_ready)
    );

    assign bus.in_ready    = s1_ready_c;
    assign bus.out_valid   = s2_valid;
    assign bus.out_lo      = W'(s2_data.lo);
    assign bus.out_hi      = W'(s2_data.hi);
    assign bus.out_swapped = s2_data.swapped;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear has priority over a coincident increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_count) begin
            cnt_d = '0;
        end else if (s2_valid && bus.out_ready && s2_data.swapped && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign swap_count = cnt_q;
endmodule

// File: tb/tb_pair_sort_pipe.sv
// Drives an ascending and a descending instance with identical traffic and
// checks both against a queue-based model of the sorting pipeline.
module tb_pair_sort_pipe;
    import pair_sort_pkg::*;

    localparam int unsigned TW = 13;
    localparam int          SAT = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [TW-1:0] in_a = '0;
    logic [TW-1:0] in_b = '0;
    logic          out_ready = 1'b1;
    logic          clear_count = 1'b0;
    logic [7:0]    sc_a, sc_d;

    always #5 clk = ~clk;

    pair_sort_pipe_if #(.W(TW)) bus_a ();
    pair_sort_pipe_if #(.W(TW)) bus_d ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_a      = in_a;
    assign bus_a.in_b      = in_b;
    assign bus_a.out_ready = out_ready;
    assign bus_d.in_valid  = in_valid;
    assign bus_d.in_a      = in_a;
    assign bus_d.in_b      = in_b;
    assign bus_d.out_ready = out_ready;

    pair_sort_pipe #(.W(TW), .DESCEND(1'b0), .CNT_W(8)) u_asc (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_a),
        .clear_count (clear_count),
        .swap_count  (sc_a)
    );

    pair_sort_pipe #(.W(TW), .DESCEND(1'b1), .CNT_W(8)) u_desc (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_d),
        .clear_count (clear_count),
        .swap_count  (sc_d)
    );

    typedef struct {
        int a;
        int b;
        int acc;
    } ent_t;

    ent_t q[$];
    int   edge_n   = 0;
    int   last_del = 0;
    int   cnt_a    = 0;
    int   cnt_d    = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    bit   last_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One clock: check outputs mid-cycle against the model, then advance it.
    task automatic cycle();
        bit exp_ir, exp_ov, acc, dlv;
        int lo_a, hi_a, lo_d, hi_d, rdy_edge;
        bit sw_a, sw_d;
        @(negedge clk);
        exp_ir = (q.size() < 2) || out_ready;
        exp_ov = 1'b0;
        if (q.size() > 0) begin
            rdy_edge = (q[0].acc + 1 > last_del) ? q[0].acc + 1 : last_del;
            exp_ov   = (edge_n >= rdy_edge);
        end
        chk("asc.in_ready",  32'(bus_a.in_ready),  32'(exp_ir));
        chk("desc.in_ready", 32'(bus_d.in_ready),  32'(exp_ir));
        chk("asc.out_valid", 32'(bus_a.out_valid), 32'(exp_ov));
        chk("desc.out_valid",32'(bus_d.out_valid), 32'(exp_ov));
        if (exp_ov) begin
            sw_a = q[0].a > q[0].b;
            sw_d = q[0].a < q[0].b;
            lo_a = sw_a ? q[0].b : q[0].a;
            hi_a = sw_a ? q[0].a : q[0].b;
            lo_d = sw_d ? q[0].b : q[0].a;
            hi_d = sw_d ? q[0].a : q[0].b;
            chk("asc.out_lo",       32'(bus_a.out_lo),      32'(lo_a));
            chk("asc.out_hi",       32'(bus_a.out_hi),      32'(hi_a));
            chk("asc.out_swapped",  32'(bus_a.out_swapped), 32'(sw_a));
            chk("desc.out_lo",      32'(bus_d.out_lo),      32'(lo_d));
            chk("desc.out_hi",      32'(bus_d.out_hi),      32'(hi_d));
            chk("desc.out_swapped", 32'(bus_d.out_swapped), 32'(sw_d));
        end
        chk("asc.swap_count",  32'(sc_a), 32'(cnt_a));
        chk("desc.swap_count", 32'(sc_d), 32'(cnt_d));
        acc = in_valid && exp_ir;
        dlv = exp_ov && out_ready;
        @(posedge clk);
        edge_n++;
        if (dlv) begin
            if (q[0].a > q[0].b && cnt_a < SAT) cnt_a++;
            if (q[0].a < q[0].b && cnt_d < SAT) cnt_d++;
            void'(q.pop_front());
            last_del = edge_n;
        end
        if (clear_count) begin
            cnt_a = 0;
            cnt_d = 0;
        end
        if (acc) q.push_back('{a: int'(in_a), b: int'(in_b), acc: edge_n});
        last_acc = acc;
        #1;
    endtask

    task automatic drive(input bit v, input int a, input int b, input bit ordy, input bit clr);
        in_valid    = v;
        in_a        = TW'(a);
        in_b        = TW'(b);
        out_ready   = ordy;
        clear_count = clr;
        cycle();
    endtask

    task automatic do_reset();
        in_valid    = 1'b0;
        clear_count = 1'b0;
        rst         = 1'b1;
        #1;
        chk("rst.asc.out_valid",  32'(bus_a.out_valid),   0);
        chk("rst.desc.out_valid", 32'(bus_d.out_valid),   0);
        chk("rst.asc.out_lo",     32'(bus_a.out_lo),      0);
        chk("rst.asc.out_hi",     32'(bus_a.out_hi),      0);
        chk("rst.asc.swapped",    32'(bus_a.out_swapped), 0);
        chk("rst.asc.count",      32'(sc_a),              0);
        chk("rst.desc.count",     32'(sc_d),              0);
        q.delete();
        cnt_a    = 0;
        cnt_d    = 0;
        last_del = 0;
        repeat (2) @(posedge clk);
        edge_n += 2;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int idx;
        int bp_a[3];
        int bp_b[3];
        int r;

        do_reset();

        // Ascending in order, no swap
        drive(1, 12, 14, 1, 0);
        repeat (3) drive(0, 0, 0, 1, 0);

        // Swap followed by a tie
        drive(1, 14, 12, 1, 0);
        drive(1, 7, 7, 1, 0);
        repeat (3) drive(0, 0, 0, 1, 0);

        // Pairs that exercise the descending instance
        drive(1, 12, 14, 1, 0);
        drive(1, 8191, 0, 1, 0);
        repeat (3) drive(0, 0, 0, 1, 0);

        // Backpressure: downstream stalled for 4 cycles
        bp_a = '{1, 3, 5};
        bp_b = '{0, 2, 4};
        idx  = 0;
        for (int c = 0; c < 16; c++) begin
            if (idx < 3) drive(1, bp_a[idx], bp_b[idx], c >= 4, 0);
            else         drive(0, 0, 0, c >= 4, 0);
            if (last_acc) idx++;
        end
        chk("bp.all_accepted", 32'(idx), 3);

        // Saturation of the ascending counter
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 8190));
            drive(1, r + 1, r, 1, 0);
        end
        repeat (3) drive(0, 0, 0, 1, 0);
        chk("sat.asc.count", 32'(sc_a), 32'(SAT));

        // Clear coinciding with a swapped output transfer
        drive(1, 9, 3, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        chk("clear.asc.count", 32'(sc_a), 0);
        drive(0, 0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int ra, rb;
            ra = int'($urandom_range(0, 8191));
            rb = ($urandom_range(0, 7) == 0) ? ra : int'($urandom_range(0, 8191));
            drive($urandom_range(0, 3) != 0, ra, rb,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
        end
        repeat (4) drive(0, 0, 0, 1, 0);

        // Reset with two pairs in flight
        drive(1, 20, 10, 0, 0);
        drive(1, 30, 40, 0, 0);
        chk("midrst.asc.valid_before", 32'(bus_a.out_valid), 1);
        do_reset();
        drive(1, 5, 6, 1, 0);
        repeat (4) drive(0, 0, 0, 1, 0);
        chk("midrst.asc.count", 32'(sc_a), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
